// File: rtl/seq_encoder.sv
// Sequential 8-to-3 encoder: emits the index of every set bit of an accepted vector, one per handshake.
// Define SEQ_ENCODER_MSB_FIRST_EN to scan from the highest set bit instead of the lowest.
module seq_encoder #(
  parameter int IN_WIDTH  = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_WIDTH-1:0] out,
  output logic                 out_last,
  output logic                 zero_flag
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state_q;
  logic [IN_WIDTH-1:0]  pending_q, pending_d, sel;
  logic [IDX_WIDTH-1:0] out_q, in_idx, pend_idx;
  logic                 out_valid_q, out_last_q, in_ready_q, zero_flag_q;

  function automatic logic [IDX_WIDTH-1:0] scan_idx(input logic [IN_WIDTH-1:0] v);
    logic [IDX_WIDTH-1:0] idx;
    idx = '0;
`ifdef SEQ_ENCODER_MSB_FIRST_EN
    for (int unsigned i = 0; i < IN_WIDTH; i++)
      if (v[i]) idx = IDX_WIDTH'(i);
`else
    // Walk downward so the last match wins, leaving the lowest set bit.
    for (int unsigned i = 0; i < IN_WIDTH; i++)
      if (v[IN_WIDTH-1-i]) idx = IDX_WIDTH'(IN_WIDTH-1-i);
`endif
    return idx;
  endfunction

  function automatic logic single_bit(input logic [IN_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - IN_WIDTH'(1))) == '0);
  endfunction

  always_comb begin
    sel        = '0;
    sel[out_q] = 1'b1;
    pending_d  = pending_q & ~sel;
    in_idx     = scan_idx(in);
    pend_idx   = scan_idx(pending_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      zero_flag_q <= 1'b0;
    end else begin
      zero_flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in != '0) begin
              state_q     <= EMIT;
              pending_q   <= in;
              out_q       <= in_idx;
              out_last_q  <= single_bit(in);
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              zero_flag_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending_q <= pending_d;
            if (pending_d == '0) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              out_q      <= pend_idx;
              out_last_q <= single_bit(pending_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_last  = out_last_q;
  assign zero_flag = zero_flag_q;

endmodule

// File: tb/tb_seq_encoder.sv
// Scoreboard bench for seq_encoder: driver pushes hand-computed {last,idx} pairs, negedge monitor compares.
// Build with SEQ_ENCODER_MSB_FIRST_EN defined to check the highest-first scan order.
module tb_seq_encoder;

  logic       clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, zero_flag;
  logic [7:0] in;
  logic [2:0] out;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  logic [3:0] sb[$];

  seq_encoder #(.IN_WIDTH(8), .IDX_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_last(out_last),
    .zero_flag(zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input bit last);
    sb.push_back({last, 3'(idx)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    while (!in_ready && n < 100) begin n++; step(); end
    check("in_ready_wait", {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1;
    in       = v;
    step();
    in_valid = 1'b0;
    in       = '0;
  endtask

  // Monitor: every cycle out_valid is high, the front entry must match (also covers stall stability).
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got idx %0d last %0b, expected no output", out, out_last);
      end else begin
        check("out_idx", {5'd0, out}, {5'd0, sb[0][2:0]});
        check("out_last", {7'd0, out_last}, {7'd0, sb[0][3]});
        if (out_ready) begin
          void'(sb.pop_front());
          hs_count++;
        end
      end
    end
  end

  initial begin
    int cnt, hs0;
    rst = 1'b1; in_valid = 1'b0; in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("rst_in_ready", {7'd0, in_ready}, 8'd1);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_out", {5'd0, out}, 8'd0);
    check("rst_zero_flag", {7'd0, zero_flag}, 8'd0);
    check("rst_out_last", {7'd0, out_last}, 8'd0);

    // Single bit
    push(2, 1);
    send(8'b0000_0100);
    check("single_valid", {7'd0, out_valid}, 8'd1);
    check("single_in_ready", {7'd0, in_ready}, 8'd0);
    step();
    check("single_idle_ready", {7'd0, in_ready}, 8'd1);
    check("single_idle_valid", {7'd0, out_valid}, 8'd0);

    // Multi-bit 8'hA3
`ifdef SEQ_ENCODER_MSB_FIRST_EN
    push(7, 0); push(5, 0); push(1, 0); push(0, 1);
`else
    push(0, 0); push(1, 0); push(5, 0); push(7, 1);
`endif
    send(8'b1010_0011);
    cnt = 0;
    while (!in_ready && cnt < 50) begin cnt++; step(); end
    check("multi_busy_cycles", 8'(cnt), 8'd4);

    // Backpressure 8'hFF with out_ready toggling
`ifdef SEQ_ENCODER_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) push(i, i == 0);
`else
    for (int i = 0; i < 8; i++) push(i, i == 7);
`endif
    hs0 = hs_count;
    send(8'hFF);
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      out_ready = ~out_ready;
      cnt++;
      step();
    end
    out_ready = 1'b1;
    check("bp_handshakes", 8'(hs_count - hs0), 8'd8);

    // Zero vector
    send(8'h00);
    check("zero_pulse", {7'd0, zero_flag}, 8'd1);
    check("zero_no_valid", {7'd0, out_valid}, 8'd0);
    check("zero_in_ready", {7'd0, in_ready}, 8'd1);
    step();
    check("zero_pulse_end", {7'd0, zero_flag}, 8'd0);

    // Vector offered during EMIT must wait for IDLE
`ifdef SEQ_ENCODER_MSB_FIRST_EN
    push(2, 0); push(1, 1); push(7, 0); push(0, 1);
`else
    push(1, 0); push(2, 1); push(0, 0); push(7, 1);
`endif
    out_ready = 1'b0;
    send(8'h06);
    in_valid = 1'b1;
    in       = 8'h81;
    repeat (3) step();
    check("ignore_in_ready", {7'd0, in_ready}, 8'd0);
    out_ready = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin cnt++; step(); end
    check("ignore_drain_cycles", 8'(cnt), 8'd2);
    step();
    in_valid = 1'b0;
    in       = '0;
    cnt = 0;
    while (!in_ready && cnt < 50) begin cnt++; step(); end
    check("ignore_second_cycles", 8'(cnt), 8'd2);

    // Reset mid-EMIT
`ifdef SEQ_ENCODER_MSB_FIRST_EN
    push(7, 0); push(6, 0); push(5, 0); push(4, 1);
`else
    push(4, 0); push(5, 0); push(6, 0); push(7, 1);
`endif
    send(8'hF0);
    step();
    check("rst_mid_remaining", 8'(sb.size()), 8'd3);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {7'd0, out_valid}, 8'd0);
    check("rst_mid_in_ready", {7'd0, in_ready}, 8'd1);
    check("rst_mid_out", {5'd0, out}, 8'd0);
    sb.delete();
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    check("post_rst_valid", {7'd0, out_valid}, 8'd0);

    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
